center_buf_wr_ctrl: RTL and testbench
=====================================

CENTER_BUF_WR_CTRL -- requirements
Module: center_buf_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: width of one buffer word.
REQ-002 SHALL have parameter DEPTH, default 32: total center_buf words, split into two banks of DEPTH/2.
REQ-003 SHALL have parameter log2_DEPTH, default 5: center_buf address width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a job.
REQ-007 SHALL have port tile_len, input, log2_DEPTH: words per tile, sampled on start.
REQ-008 SHALL have port tile_num, input, 16: tiles per job, sampled on start.
REQ-009 SHALL have ports in_vld (input, 1), in_rdy (output, 1), and in_dat (input, DATA_WIDTH): upstream stream.
REQ-010 SHALL have ports wr_en (output, 1), wr_addr (output, log2_DEPTH), and wr_dat (output, DATA_WIDTH): center_buf write port.
REQ-011 SHALL have ports tile_vld (output, 1) and tile_bank (output, 1): pulse marking a tile resident in the given bank.
REQ-012 SHALL have ports tile_done (input, 1) and tile_done_bank (input, 1): consumer releases the given bank.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1): job active; one-cycle end-of-job pulse.
REQ-014 SHALL have port stall_cnt, output, 32: upstream stall cycle count.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, and DRAIN.
REQ-016 SHALL move IDLE->FILL on start, latch parameters, and set wr_bank=0, word_cnt=0, tiles_wr=0.
REQ-017 SHALL treat a latched tile_len of 0 as 1, clamp values above DEPTH/2 to DEPTH/2, and complete a tile_num=0 job immediately: done pulses one cycle after start and the FSM returns to IDLE.
REQ-018 SHALL drive in_rdy = (state==FILL) && bank_free[wr_bank], combinationally.
REQ-019 SHALL, on handshake (in_vld&&in_rdy), register wr_en=1, wr_addr={wr_bank, word_cnt[log2_DEPTH-2:0]}, and wr_dat=in_dat at the next edge, giving 1-cycle latency; otherwise wr_en SHALL be 0.
REQ-020 SHALL, on the handshake of word tile_len-1, clear bank_free[wr_bank], toggle wr_bank, reset word_cnt, and increment tiles_wr.
REQ-021 SHALL assert tile_vld with tile_bank for exactly one cycle, one cycle after that tile's last wr_en, so the data is already written into center_buf.
REQ-022 SHALL move FILL->DRAIN when tiles_wr reaches tile_num.
REQ-023 SHALL, in DRAIN, wait until both banks are free, then pulse done and return to IDLE.
REQ-024 SHALL, on tile_done, set bank_free[tile_done_bank]; a tile_done for an already-free bank SHALL be ignored.
REQ-025 SHALL, when tile_done and bank fill-completion hit the same bank in the same cycle, apply the fill, leaving the bank not free.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL drive busy=1 in FILL and DRAIN.

Reset
REQ-028 SHALL, while rst_n=0, set the FSM to IDLE and both bank_free=1.
REQ-029 SHALL, while rst_n=0, set wr_en, tile_vld, tile_bank, done, busy, and stall_cnt to 0, and wr_addr to 0.
REQ-030 SHALL abandon any job in progress on reset, with no done pulse; wr_dat need not be reset.

Configuration
REQ-031 SHALL, with CENTER_BUF_WR_STALL_CNT_EN defined, count in stall_cnt the cycles where in_vld=1 && in_rdy=0 && busy=1, clear it on start, and saturate at 0xFFFFFFFF.
REQ-032 SHALL, without CENTER_BUF_WR_STALL_CNT_EN, tie stall_cnt to 0 and synthesize no counter.

Structure
REQ-033 SHALL place the FSM state encoding and the stall counter width in the shared CNN_defines.vh.
REQ-034 SHALL be implemented as a single module with no sub-module; the bank_free/tile-release tracker stays inline.

Verification
REQ-035 SHALL verify: tile_len=4, tile_num=2, in_vld held high, tile_done returned 3 cycles after each tile_vld -> wr_addr 0,1,2,3 then 16,17,18,19; tile_vld pulses twice (banks 0 then 1); done pulses once.
REQ-036 SHALL verify: tile_len=4, tile_num=3, no tile_done -> in_rdy drops after 8 words; a tile_done for bank 0 reopens it; the third tile writes addresses 0..3.
REQ-037 SHALL verify: tile_len=0 and tile_len=31 -> tiles of 1 and 16 words respectively.
REQ-038 SHALL verify: tile_done on bank 1 in the same cycle as the last handshake of bank 1 -> bank 1 remains full and in_rdy stays 0 until bank 0 is freed.
REQ-039 SHALL verify: rst_n pulsed low mid-FILL -> all outputs reach their reset values asynchronously, no done pulse, and a new start runs a clean job.
REQ-040 SHALL verify, with CENTER_BUF_WR_STALL_CNT_EN defined: 5 stalled cycles -> stall_cnt=5, and a new start clears it to 0.

Source files
------------

// File: rtl/center_buf_wr_ctrl_pkg.sv
// center_buf_wr_ctrl_pkg -- shared definitions for the center_buf write controller.
//
// Holds the write-controller FSM state encoding and the stall counter width so that
// the controller and any block observing it agree on both.
package center_buf_wr_ctrl_pkg;

    // Write-side job sequencing.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StDrain = 2'd2
    } wr_state_e;

    localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/center_buf_wr_ctrl.sv
// center_buf_wr_ctrl -- fills the two-bank center_buf from an upstream stream.
//
// A job is a sequence of tile_num tiles of tile_len words each. Tiles alternate between
// bank 0 (addresses 0..DEPTH/2-1) and bank 1 (DEPTH/2..DEPTH-1). A bank becomes busy
// once its tile is complete and is released by the consumer with tile_done.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, tile_len, tile_num  job launch pulse and its parameters (sampled on start)
//   in_vld, in_rdy, in_dat     upstream valid/ready stream
//   wr_en, wr_addr, wr_dat     center_buf write port (registered, 1-cycle latency)
//   tile_vld, tile_bank        one-cycle pulse: tile resident in tile_bank
//   tile_done, tile_done_bank  consumer releases tile_done_bank
//   busy, done                 job active; one-cycle end-of-job pulse
//   stall_cnt                  cycles with in_vld=1, in_rdy=0 while busy
//
// Build option: define CENTER_BUF_WR_STALL_CNT_EN to enable the stall counter;
// otherwise stall_cnt is tied to 0.
module center_buf_wr_ctrl
    import center_buf_wr_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned log2_DEPTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [log2_DEPTH-1:0]  tile_len,
    input  logic [15:0]            tile_num,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [DATA_WIDTH-1:0]  in_dat,
    output logic                   wr_en,
    output logic [log2_DEPTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_dat,
    output logic                   tile_vld,
    output logic                   tile_bank,
    input  logic                   tile_done,
    input  logic                   tile_done_bank,
    output logic                   busy,
    output logic                   done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [log2_DEPTH-1:0] HalfDepth = log2_DEPTH'(DEPTH / 2);
    localparam logic [log2_DEPTH-1:0] LenOne    = log2_DEPTH'(1);

    wr_state_e             state_q, state_d;
    logic [log2_DEPTH-1:0] len_q, len_d;
    logic [log2_DEPTH-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]           num_q, num_d;
    logic [15:0]           tiles_wr_q, tiles_wr_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [1:0]            bank_free_q, bank_free_d;
    logic                  done_d;
    logic                  hs, last_word;

    logic                  wr_en_q;
    logic [log2_DEPTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_dat_q;
    logic                  tile_end_q, tile_end_bank_q;
    logic                  tile_vld_q, tile_bank_q, done_q;

    always_comb begin
        in_rdy    = (state_q == StFill) && bank_free_q[wr_bank_q];
        hs        = in_vld && in_rdy;
        last_word = hs && (word_cnt_q == len_q - LenOne);
        busy      = (state_q != StIdle);
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        num_d       = num_q;
        word_cnt_d  = word_cnt_q;
        tiles_wr_d  = tiles_wr_q;
        wr_bank_d   = wr_bank_q;
        done_d      = 1'b0;
        bank_free_d = bank_free_q;

        // Release first so that a fill completing on the same bank overrides it below.
        if (tile_done) begin
            bank_free_d[tile_done_bank] = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d      = tile_num;
                    word_cnt_d = '0;
                    tiles_wr_d = '0;
                    wr_bank_d  = 1'b0;
                    if (tile_len == '0) begin
                        len_d = LenOne;
                    end else if (tile_len > HalfDepth) begin
                        len_d = HalfDepth;
                    end else begin
                        len_d = tile_len;
                    end
                    // An empty job finishes without leaving IDLE.
                    if (tile_num == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (last_word) begin
                    bank_free_d[wr_bank_q] = 1'b0;
                    wr_bank_d              = ~wr_bank_q;
                    word_cnt_d             = '0;
                    tiles_wr_d             = tiles_wr_q + 16'd1;
                    if (tiles_wr_d == num_q) begin
                        state_d = StDrain;
                    end
                end else if (hs) begin
                    word_cnt_d = word_cnt_q + LenOne;
                end
            end
            StDrain: begin
                if (bank_free_q == 2'b11) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= LenOne;
            num_q       <= '0;
            word_cnt_q  <= '0;
            tiles_wr_q  <= '0;
            wr_bank_q   <= 1'b0;
            bank_free_q <= 2'b11;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_q       <= num_d;
            word_cnt_q  <= word_cnt_d;
            tiles_wr_q  <= tiles_wr_d;
            wr_bank_q   <= wr_bank_d;
            bank_free_q <= bank_free_d;
        end
    end

    // tile_end_q lines up with the last wr_en of a tile; tile_vld follows one cycle
    // later so the consumer never sees a tile before its final word is in the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            tile_end_q      <= 1'b0;
            tile_end_bank_q <= 1'b0;
            tile_vld_q      <= 1'b0;
            tile_bank_q     <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            wr_en_q    <= hs;
            tile_end_q <= last_word;
            tile_vld_q <= tile_end_q;
            done_q     <= done_d;
            if (hs) begin
                wr_addr_q <= {wr_bank_q, word_cnt_q[log2_DEPTH-2:0]};
            end
            if (last_word) begin
                tile_end_bank_q <= wr_bank_q;
            end
            if (tile_end_q) begin
                tile_bank_q <= tile_end_bank_q;
            end
        end
    end

    // Data path carries no reset; wr_en qualifies it.
    always_ff @(posedge clk) begin
        if (hs) begin
            wr_dat_q <= in_dat;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_dat    = wr_dat_q;
    assign tile_vld  = tile_vld_q;
    assign tile_bank = tile_bank_q;
    assign done      = done_q;

`ifdef CENTER_BUF_WR_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (start && (state_q == StIdle)) begin
            stall_cnt_q <= '0;
        end else if (in_vld && !in_rdy && busy && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_center_buf_wr_ctrl.sv
// tb_center_buf_wr_ctrl -- directed self-checking bench for center_buf_wr_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_center_buf_wr_ctrl;

    localparam int unsigned DW    = 256;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

`ifdef CENTER_BUF_WR_STALL_CNT_EN
    localparam logic [31:0] StallExp = 32'd5;
`else
    localparam logic [31:0] StallExp = 32'd0;
`endif

    logic          clk            = 1'b0;
    logic          rst_n          = 1'b0;
    logic          start          = 1'b0;
    logic [AW-1:0] tile_len       = '0;
    logic [15:0]   tile_num       = '0;
    logic          in_vld         = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_dat         = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;
    logic          tile_vld;
    logic          tile_bank;
    logic          tile_done      = 1'b0;
    logic          tile_done_bank = 1'b0;
    logic          busy;
    logic          done;
    logic [31:0]   stall_cnt;

    center_buf_wr_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .log2_DEPTH (AW)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .tile_len       (tile_len),
        .tile_num       (tile_num),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .in_dat         (in_dat),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_dat         (wr_dat),
        .tile_vld       (tile_vld),
        .tile_bank      (tile_bank),
        .tile_done      (tile_done),
        .tile_done_bank (tile_done_bank),
        .busy           (busy),
        .done           (done),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t0       = 0;
    int done_cnt = 0;
    bit auto_rel = 1'b0;
    int addr_q[$];
    int dat_q[$];
    int tv_bank_q[$];
    int tv_cyc_q[$];
    int rel_due_q[$];
    int rel_bank_q[$];
    int exp_two_tiles[8] = '{0, 1, 2, 3, 16, 17, 18, 19};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int c);
        return 32'hD000_0000 + 32'(c);
    endfunction

    // Advance one cycle, log DUT activity, and return tile_done when auto-release is on
    // (3 cycles after each tile_vld).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en) begin
            addr_q.push_back(int'(wr_addr));
            dat_q.push_back(int'(wr_dat[31:0]));
        end
        if (tile_vld) begin
            tv_bank_q.push_back(int'(tile_bank));
            tv_cyc_q.push_back(cyc - t0);
            if (auto_rel) begin
                rel_due_q.push_back(cyc + 3);
                rel_bank_q.push_back(int'(tile_bank));
            end
        end
        if (done) done_cnt++;
        tile_done = 1'b0;
        if (rel_due_q.size() > 0 && rel_due_q[0] == cyc) begin
            tile_done      = 1'b1;
            tile_done_bank = (rel_bank_q[0] != 0);
            void'(rel_due_q.pop_front());
            void'(rel_bank_q.pop_front());
        end
        in_dat = {8{pat(cyc)}};
    endtask

    task automatic start_job(input int len, input int num);
        addr_q.delete();
        dat_q.delete();
        tv_bank_q.delete();
        tv_cyc_q.delete();
        rel_due_q.delete();
        rel_bank_q.delete();
        done_cnt = 0;
        start    = 1'b1;
        tile_len = AW'(len);
        tile_num = 16'(num);
        tick();
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic check_two_tiles(input string tag);
        check({tag, "_nwr"}, addr_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_addr%0d", tag, i), (i < addr_q.size()) ? addr_q[i] : -1,
                  exp_two_tiles[i]);
        end
        check({tag, "_ntv"}, tv_bank_q.size(), 2);
        check({tag, "_tv0_bank"}, (tv_bank_q.size() > 0) ? tv_bank_q[0] : -1, 0);
        check({tag, "_tv1_bank"}, (tv_bank_q.size() > 1) ? tv_bank_q[1] : -1, 1);
        check({tag, "_tv0_cyc"}, (tv_cyc_q.size() > 0) ? tv_cyc_q[0] : -1, 5);
        check({tag, "_tv1_cyc"}, (tv_cyc_q.size() > 1) ? tv_cyc_q[1] : -1, 9);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_tile_vld", tile_vld, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Empty job: done one cycle after start, never busy
        start_job(3, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        tick();
        check("zero_done_once", done, 0);
        check("zero_done_cnt", done_cnt, 1);

        // Two tiles of 4, consumer releases 3 cycles after each tile_vld
        in_vld   = 1'b1;
        auto_rel = 1'b1;
        start_job(4, 2);
        check("t1_rdy", in_rdy, 1);
        check("t1_no_early_wr", wr_en, 0);
        check("t1_busy", busy, 1);
        repeat (20) tick();
        check_two_tiles("t1");
        check("t1_dat_first", (dat_q.size() > 0) ? dat_q[0] : -1, pat(t0));
        check("t1_dat_last", (dat_q.size() > 7) ? dat_q[7] : -1, pat(t0 + 7));

        // Three tiles, no release: stall after 8 words; start while busy is ignored
        auto_rel = 1'b0;
        start_job(4, 3);
        repeat (10) tick();
        check("t2_rdy_closed", in_rdy, 0);
        check("t2_nwr_stalled", addr_q.size(), 8);
        check("t2_busy", busy, 1);
        tile_done      = 1'b1;
        tile_done_bank = 1'b0;
        start          = 1'b1;
        tile_len       = AW'(1);
        tile_num       = 16'd1;
        tick();
        start = 1'b0;
        check("t2_rdy_reopen", in_rdy, 1);
        repeat (4) tick();
        check("t2_nwr", addr_q.size(), 12);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_addr%0d", 8 + i), (addr_q.size() > 8 + i) ? addr_q[8 + i] : -1,
                  i);
        end
        in_vld         = 1'b0;
        tile_done      = 1'b1;
        tile_done_bank = 1'b1;
        tick();
        tile_done      = 1'b1;
        tile_done_bank = 1'b0;
        tick();
        repeat (3) tick();
        check("t2_done_cnt", done_cnt, 1);
        check("t2_idle", busy, 0);
        check("t2_tv2_bank", (tv_bank_q.size() > 2) ? tv_bank_q[2] : -1, 0);

        // tile_len 0 behaves as 1
        in_vld   = 1'b1;
        auto_rel = 1'b1;
        start_job(0, 2);
        repeat (12) tick();
        check("t3a_nwr", addr_q.size(), 2);
        check("t3a_addr0", (addr_q.size() > 0) ? addr_q[0] : -1, 0);
        check("t3a_addr1", (addr_q.size() > 1) ? addr_q[1] : -1, 16);
        check("t3a_tv0_cyc", (tv_cyc_q.size() > 0) ? tv_cyc_q[0] : -1, 2);
        check("t3a_tv1_cyc", (tv_cyc_q.size() > 1) ? tv_cyc_q[1] : -1, 3);
        check("t3a_done_cnt", done_cnt, 1);

        // tile_len 31 clamps to 16
        start_job(31, 1);
        repeat (25) tick();
        check("t3b_nwr", addr_q.size(), 16);
        check("t3b_addr_last", (addr_q.size() > 15) ? addr_q[15] : -1, 15);
        check("t3b_tv_cyc", (tv_cyc_q.size() > 0) ? tv_cyc_q[0] : -1, 17);
        check("t3b_done_cnt", done_cnt, 1);

        // Release of bank 1 coincides with its fill completion: fill wins
        auto_rel = 1'b0;
        start_job(2, 4);
        repeat (3) tick();
        tile_done      = 1'b1;
        tile_done_bank = 1'b1;
        tick();
        check("t4_rdy_after_collision", in_rdy, 0);
        repeat (2) tick();
        check("t4_rdy_hold", in_rdy, 0);
        tile_done      = 1'b1;
        tile_done_bank = 1'b0;
        tick();
        check("t4_rdy_bank0_free", in_rdy, 1);
        repeat (2) tick();
        check("t4_bank1_still_full", in_rdy, 0);
        check("t4_nwr", addr_q.size(), 6);
        check("t4_addr5", (addr_q.size() > 5) ? addr_q[5] : -1, 1);

        // Asynchronous reset mid-FILL (wr_en=1, wr_addr=1, tile_bank=1 just before)
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_wr_addr", wr_addr, 0);
        check("arst_busy", busy, 0);
        check("arst_in_rdy", in_rdy, 0);
        check("arst_tile_vld", tile_vld, 0);
        check("arst_tile_bank", tile_bank, 0);
        check("arst_done", done, 0);
        check("arst_stall", stall_cnt, 0);
        repeat (2) tick();
        check("arst_no_done", done_cnt, 0);
        check("arst_no_tile_vld", tv_cyc_q.size(), 2);
        rst_n    = 1'b1;
        auto_rel = 1'b1;
        start_job(4, 2);
        repeat (20) tick();
        check_two_tiles("t5");

        // Stall counting: two 1-word tiles fill both banks, then 5 stalled edges
        auto_rel = 1'b0;
        start_job(1, 3);
        check("t6_stall_cleared", stall_cnt, 0);
        repeat (7) tick();
        check("t6_stall_5", stall_cnt, StallExp);
        in_vld         = 1'b0;
        tile_done      = 1'b1;
        tile_done_bank = 1'b0;
        tick();
        in_vld = 1'b1;
        tick();
        in_vld         = 1'b0;
        tile_done      = 1'b1;
        tile_done_bank = 1'b1;
        tick();
        tile_done      = 1'b1;
        tile_done_bank = 1'b0;
        tick();
        repeat (3) tick();
        check("t6_done_cnt", done_cnt, 1);
        check("t6_stall_hold", stall_cnt, StallExp);
        start_job(1, 1);
        check("t6_stall_clear_on_start", stall_cnt, 0);
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        tick();
        tile_done      = 1'b1;
        tile_done_bank = 1'b0;
        repeat (4) tick();
        check("t6_last_done_cnt", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
